// File: rtl/serial_inc_scheduler.sv
// Round-robin front end for the bit-serial increment unit: grants one requester,
// streams its operand LSB-first into the serial unit and returns the tagged result.
module serial_inc_scheduler #(
  parameter int W    = 4,
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              adder_tx_start,
  output logic              adder_in,
  input  logic              adder_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_carry,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CARRY = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            grant_found_s;
  logic [IDW-1:0]  grant_id_s;
  logic [W-1:0]    operand_s;
  logic [NREQ-1:0] grant_onehot_s;

  // Round-robin search: indices at or above the pointer beat the wrapped ones,
  // and within each group the lowest index wins (descending loops, last write wins).
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      grant_found_s = grant_found_s | (req_valid[j] && (IDW'(j) < ptr_q));
      grant_id_s    = (req_valid[j] && (IDW'(j) < ptr_q)) ? IDW'(j) : grant_id_s;
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      grant_found_s = grant_found_s | (req_valid[j] && (IDW'(j) >= ptr_q));
      grant_id_s    = (req_valid[j] && (IDW'(j) >= ptr_q)) ? IDW'(j) : grant_id_s;
    end
  end

  // Operand mux and one-hot decode of the winner.
  always_comb begin
    operand_s      = '0;
    grant_onehot_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      operand_s         = (grant_id_s == IDW'(j)) ? req_data[j*W +: W] : operand_s;
      grant_onehot_s[j] = (grant_id_s == IDW'(j));
    end
  end

  // Next-state and output decode for the four-state sequencer.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    result_d       = result_q;
    carry_d        = carry_q;
    id_d           = id_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    req_ready      = '0;
    adder_tx_start = 1'b0;
    adder_in       = 1'b0;
    rsp_valid      = 1'b0;
    busy           = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // Grant is held off while reset is asserted so every output reads zero.
        if (grant_found_s && reset) begin
          req_ready = grant_onehot_s;
          shift_d   = operand_s;
          id_d      = grant_id_s;
          cnt_d     = '0;
          ptr_d     = (grant_id_s == IDW'(NREQ - 1)) ? '0 : grant_id_s + IDW'(1);
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        adder_in         = shift_q[0];
        adder_tx_start   = (cnt_q == '0);
        result_d[cnt_q]  = adder_out;
        shift_d          = shift_q >> 1;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = CARRY;
        end else begin
          state_d = SHIFT;
        end
      end
      CARRY: begin
        carry_d = adder_out;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  assign rsp_data  = result_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule
